branch_unit: RTL and testbench
==============================

Name: branch_unit

Overview:
- Branch resolution unit with an integrated bimodal predictor.
- The fetch stage queries it for a taken/not-taken prediction indexed by PC.
- The execute stage presents resolved branches. The unit evaluates the condition, compares it with the prediction carried down the pipe, updates a table of 2-bit saturating counters, and issues a registered redirect on mispredict.

Parameters:
- XLEN, 32, data/PC width (imhotep_pkg value).
- BHT_ENTRIES, 64, predictor entries; power of two, >= 2.
- IDX_W, $clog2(BHT_ENTRIES), derived index width; not to be overridden.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- pred_pc_i  in  XLEN  fetch PC to predict.
- pred_taken_o  out  1  combinational prediction for pred_pc_i (counter MSB).
- res_valid_i  in  1  resolve request valid.
- res_pc_i  in  XLEN  PC of the resolving instruction.
- a_i  in  XLEN  rs1 operand.
- b_i  in  XLEN  rs2 operand.
- op_i  in  op_csr_e  condition select.
- target_i  in  XLEN  computed taken target.
- pred_taken_i  in  1  prediction made at fetch for this instruction.
- flush_i  in  1  kill in-flight result.
- res_valid_o  out  1  registered result valid (1-cycle pulse).
- taken_o  out  1  resolved direction.
- mispredict_o  out  1  resolved direction differs from pred_taken_i.
- redirect_pc_o  out  XLEN  correct next PC when mispredict_o.
- error_o  out  1  illegal op_i on a valid request.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_ni. All state is reset on the clk_i edge while rst_ni=0.
- Reset values:
  - every BHT counter = 2'b01 (weakly not-taken);
  - res_valid_o, taken_o, mispredict_o, error_o = 0;
  - redirect_pc_o = 0.
- Index: idx = pc[IDX_W+1:2] for both lookup and update. Bits [1:0] are ignored.
- Prediction: pred_taken_o = bht[idx(pred_pc_i)][1]. Purely combinational, no latency.
- Condition evaluation (combinational, on a_i/b_i):
  - CSR_BEQ: ==
  - CSR_BNE: !=
  - CSR_BLT: signed <
  - CSR_BGE: signed >=
  - CSR_BLTU: unsigned <
  - CSR_BGEU: unsigned >=
  - CSR_JMP: 1
  - CSR_NOP: 0
  - Any other encoding: taken=0 and error.
  - Signed compares use full XLEN signed interpretation.
- Output latency: results are registered, visible exactly one cycle after the res_valid_i=1 cycle.
- Output register load: when res_valid_i=1 and flush_i=0, at the next edge:
  - res_valid_o=1;
  - taken_o = cond;
  - mispredict_o = (cond != pred_taken_i) && !err;
  - error_o = err;
  - redirect_pc_o = cond ? target_i : res_pc_i + 4 (XLEN wrap-around, no overflow flag).
- Idle cycles: res_valid_o=0. taken_o, mispredict_o and error_o are forced to 0; redirect_pc_o holds its last value.
- flush_i=1: the next cycle has res_valid_o=0 and no BHT update, regardless of res_valid_i. flush_i asserted while res_valid_o=1 does not retract the current output.
- BHT update: on an accepted request with a conditional op only (BEQ..BGEU), on the same edge as the output register:
  - taken: counter increments, saturating at 2'b11;
  - not taken: counter decrements, saturating at 2'b00.
  - JMP, NOP and illegal ops never update the table.
- Same-index collision: a lookup and an update to the same index in the same cycle return the pre-update value (read-before-write). The new value is visible from the next cycle.
- Reset mid-operation: any pending result is discarded and all counters are reinitialised in one cycle.
- No backpressure. A new request may be accepted every cycle; back-to-back updates to the same index accumulate correctly.

Optional Feature:
- Macro: BRANCH_PERF_CNT_EN.
- When defined, add the following outputs:
  - branch_cnt_o [31:0]: counts accepted conditional requests;
  - mispredict_cnt_o [31:0]: counts accepted mispredicts, including JMP mispredicts.
- Counter behaviour: both counters reset to 0 and wrap at 2^32. Both increment on the same edge as res_valid_o rises.
- When undefined, the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, then pred_pc_i=0x100 -> pred_taken_o=0. The first BEQ at 0x100 with a=b=5, pred_taken_i=0, target=0x200 -> next cycle res_valid_o=1, taken_o=1, mispredict_o=1, redirect_pc_o=0x200. The following cycle pred_taken_o=1.
- Signed vs unsigned: BLT with a=0xFFFFFFFF, b=1 -> taken_o=1. BLTU with the same operands -> taken_o=0. BGEU with the same operands -> taken_o=1.
- Saturation: 4 taken BNE at 0x40, then 1 not-taken -> prediction remains 1. A second not-taken -> prediction 0. Three more not-taken -> counter 00, and one taken still gives prediction 0.
- Not-taken mispredict at res_pc_i=0xFFFFFFFC with pred_taken_i=1 -> redirect_pc_o=0x00000000 (wrap), mispredict_o=1.
- flush_i=1 together with res_valid_i=1 -> res_valid_o=0 next cycle, and the counter at that index is unchanged. An illegal op_i -> error_o=1, mispredict_o=0, no BHT change.
- Aliasing and collision: update 0x104 and 0x204 (same index, BHT_ENTRIES=64) with a lookup of 0x104 in the same cycle -> the lookup sees the old value. With BRANCH_PERF_CNT_EN: after 10 conditionals with 3 mispredicts -> branch_cnt_o=10, mispredict_cnt_o=3.

Source files
------------

// File: rtl/branch_unit.sv
// branch_unit: branch resolution with an integrated bimodal predictor.
//
// The fetch stage looks up a 2-bit saturating counter table (BHT) by PC to
// get a taken/not-taken prediction. The execute stage presents resolved
// branches; the unit evaluates the condition, flags a mispredict against
// the prediction carried down the pipe, trains the BHT on conditional
// branches and registers a redirect target one cycle later.
//
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   pred_pc_i           fetch PC to predict
//   pred_taken_o        combinational prediction (counter MSB)
//   res_valid_i         resolve request valid
//   res_pc_i            PC of the resolving instruction
//   a_i, b_i            rs1 / rs2 operands
//   op_i                condition select (imhotep_pkg::op_csr_e)
//   target_i            computed taken target
//   pred_taken_i        prediction made at fetch for this instruction
//   flush_i             kill in-flight result (no output, no BHT update)
//   res_valid_o         registered result valid (1-cycle pulse)
//   taken_o             resolved direction
//   mispredict_o        resolved direction differs from pred_taken_i
//   redirect_pc_o       correct next PC (holds when idle)
//   error_o             illegal op_i on a valid request
//
// Optional build macro BRANCH_PERF_CNT_EN adds:
//   branch_cnt_o        accepted conditional branches (wraps at 2^32)
//   mispredict_cnt_o    accepted mispredicts, jumps included (wraps at 2^32)

package imhotep_pkg;
  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    CSR_BEQ  = 4'd0,
    CSR_BNE  = 4'd1,
    CSR_BLT  = 4'd2,
    CSR_BGE  = 4'd3,
    CSR_BLTU = 4'd4,
    CSR_BGEU = 4'd5,
    CSR_JMP  = 4'd6,
    CSR_NOP  = 4'd7
  } op_csr_e;
endpackage

module branch_unit #(
  parameter int unsigned XLEN        = imhotep_pkg::XLEN,
  parameter int unsigned BHT_ENTRIES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [XLEN-1:0]       pred_pc_i,
  output logic                  pred_taken_o,
  input  logic                  res_valid_i,
  input  logic [XLEN-1:0]       res_pc_i,
  input  logic [XLEN-1:0]       a_i,
  input  logic [XLEN-1:0]       b_i,
  input  imhotep_pkg::op_csr_e  op_i,
  input  logic [XLEN-1:0]       target_i,
  input  logic                  pred_taken_i,
  input  logic                  flush_i,
  output logic                  res_valid_o,
  output logic                  taken_o,
  output logic                  mispredict_o,
  output logic [XLEN-1:0]       redirect_pc_o,
  output logic                  error_o
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0]           branch_cnt_o,
  output logic [31:0]           mispredict_cnt_o
`endif
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_next;
  logic             cond;
  logic             err;
  logic             is_cond;
  logic             accept;
  logic             mispredict;
  logic [XLEN-1:0]  next_pc;
  logic             unused_pc_bits;

  assign pred_idx       = pred_pc_i[IDX_W+1:2];
  assign res_idx        = res_pc_i[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc_i[XLEN-1:IDX_W+2], pred_pc_i[1:0]};

  // Read-before-write: a same-cycle update to this index only shows up
  // after the edge.
  assign pred_taken_o = bht[pred_idx][1];

  assign accept     = res_valid_i && !flush_i;
  assign next_pc    = res_pc_i + XLEN'(4);
  assign mispredict = (cond != pred_taken_i) && !err;

  always_comb begin
    cond    = 1'b0;
    err     = 1'b0;
    is_cond = 1'b1;
    case (op_i)
      imhotep_pkg::CSR_BEQ:  cond = (a_i == b_i);
      imhotep_pkg::CSR_BNE:  cond = (a_i != b_i);
      imhotep_pkg::CSR_BLT:  cond = ($signed(a_i) <  $signed(b_i));
      imhotep_pkg::CSR_BGE:  cond = ($signed(a_i) >= $signed(b_i));
      imhotep_pkg::CSR_BLTU: cond = (a_i <  b_i);
      imhotep_pkg::CSR_BGEU: cond = (a_i >= b_i);
      imhotep_pkg::CSR_JMP: begin
        cond    = 1'b1;
        is_cond = 1'b0;
      end
      imhotep_pkg::CSR_NOP: begin
        cond    = 1'b0;
        is_cond = 1'b0;
      end
      default: begin
        cond    = 1'b0;
        err     = 1'b1;
        is_cond = 1'b0;
      end
    endcase
  end

  always_comb begin
    ctr_cur  = bht[res_idx];
    ctr_next = ctr_cur;
    if (cond) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (accept && is_cond) begin
      bht[res_idx] <= ctr_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      res_valid_o   <= 1'b0;
      taken_o       <= 1'b0;
      mispredict_o  <= 1'b0;
      error_o       <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      res_valid_o <= accept;
      if (accept) begin
        taken_o       <= cond;
        mispredict_o  <= mispredict;
        error_o       <= err;
        redirect_pc_o <= cond ? target_i : next_pc;
      end else begin
        taken_o      <= 1'b0;
        mispredict_o <= 1'b0;
        error_o      <= 1'b0;
      end
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      branch_cnt_o     <= '0;
      mispredict_cnt_o <= '0;
    end else if (accept) begin
      if (is_cond)    branch_cnt_o     <= branch_cnt_o + 32'd1;
      if (mispredict) mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
    end
  end
`else
  // Performance counters are not built.
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit.
module tb_branch_unit;
  import imhotep_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      pred_pc;
  logic             pred_taken_out;
  logic             res_valid_in;
  logic [31:0]      res_pc;
  logic [31:0]      a;
  logic [31:0]      b;
  op_csr_e          op;
  logic [31:0]      target;
  logic             pred_taken_in;
  logic             flush;
  logic             res_valid_out;
  logic             taken;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic             error;
`ifdef BRANCH_PERF_CNT_EN
  logic [31:0]      branch_cnt;
  logic [31:0]      mispredict_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_unit #(.XLEN(32), .BHT_ENTRIES(64)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pred_pc_i     (pred_pc),
    .pred_taken_o  (pred_taken_out),
    .res_valid_i   (res_valid_in),
    .res_pc_i      (res_pc),
    .a_i           (a),
    .b_i           (b),
    .op_i          (op),
    .target_i      (target),
    .pred_taken_i  (pred_taken_in),
    .flush_i       (flush),
    .res_valid_o   (res_valid_out),
    .taken_o       (taken),
    .mispredict_o  (mispredict),
    .redirect_pc_o (redirect_pc),
    .error_o       (error)
`ifdef BRANCH_PERF_CNT_EN
    ,
    .branch_cnt_o     (branch_cnt),
    .mispredict_cnt_o (mispredict_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one resolve request (inputs only; caller ticks).
  task automatic drive(input op_csr_e o, input logic [31:0] pc, input logic [31:0] ra,
                       input logic [31:0] rb, input logic [31:0] tgt, input logic pt);
    res_valid_in  = 1'b1;
    op            = o;
    res_pc        = pc;
    a             = ra;
    b             = rb;
    target        = tgt;
    pred_taken_in = pt;
  endtask

  task automatic issue(input op_csr_e o, input logic [31:0] pc, input logic [31:0] ra,
                       input logic [31:0] rb, input logic [31:0] tgt, input logic pt);
    drive(o, pc, ra, rb, tgt, pt);
    tick();
    res_valid_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pred_pc = '0; res_valid_in = 1'b0; res_pc = '0; a = '0; b = '0;
    op = CSR_NOP; target = '0; pred_taken_in = 1'b0; flush = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(res_valid_out), 32'd0);
    check("rst_taken", 32'(taken), 32'd0);
    check("rst_mispred", 32'(mispredict), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_redirect", redirect_pc, 32'h0);
    rst_n = 1'b1;
    tick();

    // First BEQ at 0x100: weakly not-taken -> mispredict, then trains to taken
    pred_pc = 32'h100; #1;
    check("pred_0x100_init", 32'(pred_taken_out), 32'd0);
    issue(CSR_BEQ, 32'h100, 32'd5, 32'd5, 32'h200, 1'b0);
    check("beq_valid", 32'(res_valid_out), 32'd1);
    check("beq_taken", 32'(taken), 32'd1);
    check("beq_mispred", 32'(mispredict), 32'd1);
    check("beq_redirect", redirect_pc, 32'h200);
    check("pred_0x100_trained", 32'(pred_taken_out), 32'd1);
    tick();
    check("idle_valid", 32'(res_valid_out), 32'd0);
    check("idle_taken", 32'(taken), 32'd0);
    check("idle_mispred", 32'(mispredict), 32'd0);
    check("idle_redirect_hold", redirect_pc, 32'h200);

    // Signed vs unsigned compares
    issue(CSR_BLT, 32'h380, 32'hFFFF_FFFF, 32'd1, 32'h500, 1'b0);
    check("blt_taken", 32'(taken), 32'd1);
    check("blt_redirect", redirect_pc, 32'h500);
    issue(CSR_BLTU, 32'h384, 32'hFFFF_FFFF, 32'd1, 32'h500, 1'b0);
    check("bltu_taken", 32'(taken), 32'd0);
    check("bltu_mispred", 32'(mispredict), 32'd0);
    check("bltu_redirect", redirect_pc, 32'h388);
    issue(CSR_BGEU, 32'h388, 32'hFFFF_FFFF, 32'd1, 32'h600, 1'b1);
    check("bgeu_taken", 32'(taken), 32'd1);
    check("bgeu_mispred", 32'(mispredict), 32'd0);
    issue(CSR_BGE, 32'h38C, 32'hFFFF_FFFF, 32'd1, 32'h600, 1'b1);
    check("bge_taken", 32'(taken), 32'd0);
    check("bge_mispred", 32'(mispredict), 32'd1);

    // Saturation at 0x40 (index 16), back-to-back updates
    pred_pc = 32'h40;
    for (int i = 0; i < 4; i++) issue(CSR_BNE, 32'h40, 32'd1, 32'd2, 32'h80, 1'b1);
    check("sat_bne_mispred", 32'(mispredict), 32'd0);
    check("sat_after_4_taken", 32'(pred_taken_out), 32'd1);
    issue(CSR_BNE, 32'h40, 32'd3, 32'd3, 32'h80, 1'b1);
    check("sat_nt1_mispred", 32'(mispredict), 32'd1);
    check("sat_nt1_redirect", redirect_pc, 32'h44);
    check("sat_after_nt1", 32'(pred_taken_out), 32'd1);
    issue(CSR_BNE, 32'h40, 32'd3, 32'd3, 32'h80, 1'b1);
    check("sat_after_nt2", 32'(pred_taken_out), 32'd0);
    for (int i = 0; i < 3; i++) issue(CSR_BNE, 32'h40, 32'd3, 32'd3, 32'h80, 1'b0);
    issue(CSR_BNE, 32'h40, 32'd1, 32'd2, 32'h80, 1'b0);
    check("sat_floor_then_taken", 32'(pred_taken_out), 32'd0);

    // Fall-through wrap on a not-taken mispredict
    issue(CSR_BEQ, 32'hFFFF_FFFC, 32'd1, 32'd2, 32'h1234, 1'b1);
    check("wrap_taken", 32'(taken), 32'd0);
    check("wrap_mispred", 32'(mispredict), 32'd1);
    check("wrap_redirect", redirect_pc, 32'h0);

    // Flush with a valid request: no output, no training (index 16 is at 01)
    flush = 1'b1;
    issue(CSR_BNE, 32'h40, 32'd1, 32'd2, 32'h80, 1'b0);
    flush = 1'b0;
    check("flush_valid", 32'(res_valid_out), 32'd0);
    check("flush_no_update", 32'(pred_taken_out), 32'd0);

    // Flush arriving while a result is out does not retract it
    issue(CSR_JMP, 32'h700, 32'd0, 32'd0, 32'h900, 1'b1);
    flush = 1'b1; #1;
    check("flush_late_valid", 32'(res_valid_out), 32'd1);
    check("jmp_redirect", redirect_pc, 32'h900);
    check("jmp_mispred", 32'(mispredict), 32'd0);
    tick();
    flush = 1'b0;
    check("flush_late_next", 32'(res_valid_out), 32'd0);

    // Illegal op and NOP at 0x100 (counter 10): neither may train
    pred_pc = 32'h100;
    issue(op_csr_e'(4'hF), 32'h100, 32'd7, 32'd7, 32'h300, 1'b1);
    check("illegal_valid", 32'(res_valid_out), 32'd1);
    check("illegal_error", 32'(error), 32'd1);
    check("illegal_mispred", 32'(mispredict), 32'd0);
    check("illegal_taken", 32'(taken), 32'd0);
    check("illegal_no_update", 32'(pred_taken_out), 32'd1);
    issue(CSR_NOP, 32'h100, 32'd7, 32'd7, 32'h300, 1'b1);
    check("nop_mispred", 32'(mispredict), 32'd1);
    check("nop_error", 32'(error), 32'd0);
    check("nop_redirect", redirect_pc, 32'h104);
    check("nop_no_update", 32'(pred_taken_out), 32'd1);

    // Aliasing 0x104 / 0x204 (index 1) with same-cycle lookup
    pred_pc = 32'h104;
    drive(CSR_BEQ, 32'h104, 32'd9, 32'd9, 32'h10, 1'b0); #1;
    check("collide_old_value", 32'(pred_taken_out), 32'd0);
    tick();
    check("collide_new_value", 32'(pred_taken_out), 32'd1);
    drive(CSR_BNE, 32'h204, 32'd9, 32'd9, 32'h10, 1'b1);
    tick();
    drive(CSR_BNE, 32'h204, 32'd9, 32'd9, 32'h10, 1'b1); #1;
    check("alias_mid", 32'(pred_taken_out), 32'd0);
    tick();
    res_valid_in = 1'b0;
    check("alias_final", 32'(pred_taken_out), 32'd0);

    // Reset mid-operation discards pending result and reinitialises table
    pred_pc = 32'h100;
    issue(CSR_BEQ, 32'h100, 32'd1, 32'd1, 32'h20, 1'b0);
    rst_n = 1'b0;
    drive(CSR_BEQ, 32'h100, 32'd1, 32'd1, 32'h20, 1'b0);
    tick();
    res_valid_in = 1'b0;
    rst_n = 1'b1;
    check("midrst_valid", 32'(res_valid_out), 32'd0);
    check("midrst_redirect", redirect_pc, 32'h0);
    check("midrst_bht", 32'(pred_taken_out), 32'd0);

`ifdef BRANCH_PERF_CNT_EN
    check("perf_rst_branch", branch_cnt, 32'd0);
    check("perf_rst_mispred", mispredict_cnt, 32'd0);
    for (int i = 0; i < 10; i++) issue(CSR_BEQ, 32'h500, 32'd4, 32'd4, 32'h600, (i < 3) ? 1'b0 : 1'b1);
    issue(CSR_JMP, 32'h504, 32'd0, 32'd0, 32'h600, 1'b0);
    check("perf_branch", branch_cnt, 32'd10);
    check("perf_mispred", mispredict_cnt, 32'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
